mips_boot_sequencer: RTL
========================

# mips_boot_sequencer

Parametrised program-load and run-control block for the MIPS32 pipeline. Accepts a stream of (address, word) beats and writes them into the unified instruction/data memory. Then initialises the register file, releases the core on `start`, counts run cycles, and reports halt or watchdog timeout. It moves the load / init / wait-for-halt sequence out of bench initial blocks into synthesisable RTL.

## Interface
- `ADDR_W`, 10: memory word-address width.
- `DATA_W`, 32: memory/register word width.
- `NREG`, 32: register-file entries; `RA_W = $clog2(NREG)`.
- `REG_INIT_IDX`, 1: 1 → `Reg[k] = k`; 0 → `Reg[k] = 0`.
- `TIMEOUT`, 1024: run-cycle watchdog limit, 1 ≤ TIMEOUT < 2^32.

Ports:
- `clk1`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `ld_valid`  in  1  load beat valid.
- `ld_ready`  out  1  load beat accepted when `ld_valid & ld_ready`.
- `ld_addr`  in  ADDR_W  target word address.
- `ld_data`  in  DATA_W  word to write.
- `ld_last`  in  1  final beat of the image.
- `mem_we`  out  1  memory write strobe.
- `mem_addr`  out  ADDR_W  memory write address.
- `mem_wdata`  out  DATA_W  memory write data.
- `reg_we`  out  1  register-file write strobe.
- `reg_addr`  out  RA_W  register index.
- `reg_wdata`  out  DATA_W  register init value.
- `start`  in  1  run request / restart pulse.
- `cpu_run`  out  1  core enable; low holds the core with PC=0, HALTED=0, TAKEN_BRANCH=0.
- `cpu_halted`  in  1  core HALTED flag (HLT retired).
- `done`  out  1  halted normally.
- `timeout`  out  1  watchdog expired.
- `cycles`  out  32  run-cycle count.

## Operation
- States: LOAD, REGINIT, WAIT_START, RUN, DONE, TMO. Reset state is LOAD.
- Outputs while `reset` is high: all 0, except `ld_ready`. `ld_ready` is 0 while `reset` is high and 1 from the first edge after release.
- LOAD:
  - `ld_ready = 1`.
  - Each accepted beat is written to memory: `mem_we/mem_addr/mem_wdata` are registered copies of the beat, valid the cycle after acceptance, with `mem_we` high for exactly one cycle.
  - Throughput is one beat per cycle. Gaps in `ld_valid` are allowed.
  - An accepted beat with `ld_last` moves to REGINIT.
- REGINIT:
  - An index counter k runs 0..NREG-1, one per cycle.
  - `reg_we = 1`, `reg_addr = k`, `reg_wdata = REG_INIT_IDX ? k : 0`.
  - After k = NREG-1 the state moves to WAIT_START.
- WAIT_START: `start` moves to RUN and clears `cycles`.
- RUN:
  - `cpu_run = 1`.
  - Priority each cycle:
    1. `cpu_halted` → DONE, `cycles` holds.
    2. Otherwise, if `cycles == TIMEOUT-1` → TMO and `cycles <= TIMEOUT`.
    3. Otherwise `cycles++`.
- DONE: `done = 1`, `cpu_run = 0`. `start` → LOAD and clears `done`, `timeout` and `cycles`.
- TMO: `timeout = 1`, `cpu_run = 0`. `start` → LOAD with the same clearing as DONE.
- `start` is ignored in LOAD, REGINIT and RUN.
- `ld_valid` outside LOAD is ignored (`ld_ready = 0`).
- Reset mid-operation: state returns to LOAD and all counters clear. Memory and register contents already written are not scrubbed.
- `ld_addr` beyond 2^ADDR_W cannot occur (width-limited). Duplicate addresses are allowed; the last write wins.

## Timing
- `ld_ready`, `cpu_run`, `done`, `timeout` and `reg_*` decode from registered state only; there is no combinational path from inputs.
- `mem_*` latency: 1 cycle after acceptance.
- Last beat accepted at edge N:
  - REGINIT begins at N+1, concurrent with the last `mem_we`.
  - `reg_we` is high for cycles N+1..N+NREG.
  - WAIT_START is reached at N+NREG+1.
- `start` sampled at edge S: `cpu_run` is high from S until the edge that samples `cpu_halted`. `done` rises on that same edge.
- `cycles` equals the number of RUN cycles in which `cpu_halted` was low.

## Structure
- `mips_pkg` holds:
  - the state enum `boot_state_t`;
  - `DATA_W_DEF = 32`;
  - `OPC_HLT = 6'h3f`, shared with the core decoder.
- Sub-module `mips_run_watchdog`:
  - owns `cycles`, the TIMEOUT compare and halt priority;
  - inputs `en`, `clr`, `halted`;
  - outputs `cycles`, `expired`.
- The parent module holds the FSM, load register stage and REGINIT counter.

## Test plan
- Load image, then REGINIT:
  - Stimulus: beats (0,0x28010078), (1,0x0ce77800), (2,0x20220000), …, (7,0xfc000000), (120,85, last), back-to-back.
  - Required: `mem_we` on 9 consecutive cycles with matching addr/data, then `reg_we` on 32 cycles with `reg_wdata == reg_addr`, then WAIT_START.
- Gapped load and foreign beats:
  - Stimulus: beats with idle cycles between them; `ld_valid` held high during RUN.
  - Required: no writes outside LOAD and `ld_ready == 0` in RUN.
- Normal halt: `start`, then `cpu_halted` rises after 40 run cycles → `done = 1`, `cycles = 40`, `cpu_run = 0`, `timeout = 0`.
- Watchdog: TIMEOUT = 64 and `cpu_halted` held low → `timeout = 1` after 64 run cycles, `cycles = 64`, `cpu_run = 0`.
- Halt/timeout race: `cpu_halted` asserted on the cycle `cycles == TIMEOUT-1` → DONE, `cycles = TIMEOUT-1`, `timeout = 0`.
- Reset mid-REGINIT at k = 10:
  - Required: all outputs 0 immediately (asynchronous), `ld_ready = 1` one edge after release, `cycles = 0`.
  - A subsequent `start` in DONE restarts LOAD, with flags cleared.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS32 boot / run-control path.
package mips_pkg;

    typedef enum logic [2:0] {
        ST_LOAD       = 3'd0,
        ST_REGINIT    = 3'd1,
        ST_WAIT_START = 3'd2,
        ST_RUN        = 3'd3,
        ST_DONE       = 3'd4,
        ST_TMO        = 3'd5
    } boot_state_t;

    localparam int DATA_W_DEF = 32;

    localparam logic [5:0] OPC_HLT = 6'h3f;

    function automatic logic [31:0] reg_init_word(input logic [31:0] idx, input bit by_index);
        return by_index ? idx : 32'd0;
    endfunction

endpackage

// File: rtl/mips_run_watchdog.sv
// Run-cycle counter with watchdog compare; a halted cycle always wins over expiry.
module mips_run_watchdog #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic        clk1,
    input  logic        reset,
    input  logic        en,
    input  logic        clr,
    input  logic        halted,
    output logic [31:0] cycles,
    output logic        expired
);

    localparam logic [31:0] CNT_LAST  = TIMEOUT - 32'd1;
    localparam logic [31:0] CNT_LIMIT = TIMEOUT;

    logic [31:0] cycles_r;
    logic        count_s;

    assign count_s = en && !halted;
    assign expired = count_s && (cycles_r == CNT_LAST);
    assign cycles  = cycles_r;

    // Count only non-halted run cycles; saturate at the limit on expiry.
    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            cycles_r <= 32'd0;
        end else if (clr) begin
            cycles_r <= 32'd0;
        end else if (expired) begin
            cycles_r <= CNT_LIMIT;
        end else if (count_s) begin
            cycles_r <= cycles_r + 32'd1;
        end else begin
            cycles_r <= cycles_r;
        end
    end

endmodule

// File: rtl/mips_boot_sequencer.sv
// Program load, register-file init and run control for the MIPS32 core.
module mips_boot_sequencer
    import mips_pkg::*;
#(
    parameter int          ADDR_W       = 10,
    parameter int          DATA_W       = DATA_W_DEF,
    parameter int          NREG         = 32,
    parameter int          REG_INIT_IDX = 1,
    parameter int unsigned TIMEOUT      = 1024,
    localparam int         RA_W         = $clog2(NREG)
) (
    input  logic              clk1,
    input  logic              reset,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              reg_we,
    output logic [RA_W-1:0]   reg_addr,
    output logic [DATA_W-1:0] reg_wdata,
    input  logic              start,
    output logic              cpu_run,
    input  logic              cpu_halted,
    output logic              done,
    output logic              timeout,
    output logic [31:0]       cycles
);

    localparam logic [RA_W-1:0] K_LAST = RA_W'(NREG - 1);
    localparam logic [RA_W-1:0] K_STEP = RA_W'(32'd1);
    localparam logic [RA_W-1:0] K_ZERO = {RA_W{1'b0}};

    boot_state_t       state_r;
    boot_state_t       state_s;
    logic [RA_W-1:0]   k_r;
    logic [RA_W-1:0]   k_s;
    logic              accept_s;
    logic              run_s;
    logic              wd_clr_s;
    logic              wd_expired_s;
    logic              ld_ready_r;
    logic              reg_we_r;
    logic              cpu_run_r;
    logic              done_r;
    logic              timeout_r;
    logic              mem_we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_wdata_r;

    // ld_ready_r is only ever set while in LOAD, so it doubles as the LOAD qualifier.
    assign accept_s = ld_valid && ld_ready_r;
    assign run_s    = (state_r == ST_RUN);

    // Next-state, REGINIT index and watchdog clear decode.
    always_comb begin
        state_s  = state_r;
        k_s      = k_r;
        wd_clr_s = 1'b0;
        case (state_r)
            ST_LOAD: begin
                if (accept_s && ld_last) begin
                    state_s = ST_REGINIT;
                end else begin
                    state_s = ST_LOAD;
                end
            end
            ST_REGINIT: begin
                if (k_r == K_LAST) begin
                    state_s = ST_WAIT_START;
                    k_s     = K_ZERO;
                end else begin
                    k_s = k_r + K_STEP;
                end
            end
            ST_WAIT_START: begin
                if (start) begin
                    state_s  = ST_RUN;
                    wd_clr_s = 1'b1;
                end else begin
                    state_s = ST_WAIT_START;
                end
            end
            ST_RUN: begin
                if (cpu_halted) begin
                    state_s = ST_DONE;
                end else if (wd_expired_s) begin
                    state_s = ST_TMO;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DONE, ST_TMO: begin
                if (start) begin
                    state_s  = ST_LOAD;
                    wd_clr_s = 1'b1;
                end else begin
                    state_s = state_r;
                end
            end
            default: begin
                state_s = ST_LOAD;
                k_s     = K_ZERO;
            end
        endcase
    end

    // State and REGINIT index registers.
    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            state_r <= ST_LOAD;
            k_r     <= K_ZERO;
        end else begin
            state_r <= state_s;
            k_r     <= k_s;
        end
    end

    // Status flags registered from the next state: aligned with the state, glitch-free.
    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            ld_ready_r <= 1'b0;
            reg_we_r   <= 1'b0;
            cpu_run_r  <= 1'b0;
            done_r     <= 1'b0;
            timeout_r  <= 1'b0;
        end else begin
            ld_ready_r <= (state_s == ST_LOAD);
            reg_we_r   <= (state_s == ST_REGINIT);
            cpu_run_r  <= (state_s == ST_RUN);
            done_r     <= (state_s == ST_DONE);
            timeout_r  <= (state_s == ST_TMO);
        end
    end

    // Load register stage: one-cycle copy of each accepted beat.
    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wdata_r <= {DATA_W{1'b0}};
        end else if (accept_s) begin
            mem_we_r    <= 1'b1;
            mem_addr_r  <= ld_addr;
            mem_wdata_r <= ld_data;
        end else begin
            mem_we_r    <= 1'b0;
            mem_addr_r  <= mem_addr_r;
            mem_wdata_r <= mem_wdata_r;
        end
    end

    mips_run_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk1    (clk1),
        .reset   (reset),
        .en      (run_s),
        .clr     (wd_clr_s),
        .halted  (cpu_halted),
        .cycles  (cycles),
        .expired (wd_expired_s)
    );

    assign ld_ready  = ld_ready_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign reg_we    = reg_we_r;
    assign reg_addr  = k_r;
    assign reg_wdata = DATA_W'(reg_init_word(32'(k_r), REG_INIT_IDX != 0));
    assign cpu_run   = cpu_run_r;
    assign done      = done_r;
    assign timeout   = timeout_r;

endmodule
